// File: rtl/accumulator_pkg.sv
// Shared constants for the Somador accumulator datapath.
package accumulator_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam logic [DefaultWidth-1:0] Zero = '0;

endpackage

// File: rtl/accumulator_somador.sv
// WIDTH-bit unsigned combinational adder with carry-out.
module somador #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];

endmodule

// File: rtl/accumulator.sv
// Running-sum accumulator with a separately latched output register and sticky carry flag.
module accumulator
    import accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             transf,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] sum;
    logic             cout;

    somador #(
        .WIDTH(WIDTH)
    ) u_somador (
        .a   (acc_q),
        .b   (in),
        .sum (sum),
        .cout(cout)
    );

    // out samples the pre-add acc, so a same-edge load shows up only on a later transfer.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        out_d = out_q;
        if (load) begin
            acc_d = sum;
            ovf_d = ovf_q | cout;
        end
        if (transf) begin
            out_d = acc_q;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            acc_q <= WIDTH'(Zero);
            out_q <= WIDTH'(Zero);
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out = out_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_accumulator.sv
// Directed self-checking bench for the accumulator.
module tb_accumulator;

    logic        clk;
    logic        clear;
    logic        load;
    logic        transf;
    logic [15:0] in;
    logic [15:0] out;
    logic        ovf;

    int checks;
    int failures;

    accumulator #(
        .WIDTH(16)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .load  (load),
        .transf(transf),
        .in    (in),
        .out   (out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive between edges, then sample 1ns after the rising edge.
    task automatic step(input logic l, input logic t, input logic [15:0] d);
        @(negedge clk);
        load   = l;
        transf = t;
        in     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        #1;
        clear = 1'b0;
        load  = 1'b0;
        transf = 1'b0;
    endtask

    logic [15:0] pow;
    logic [15:0] model;

    initial begin
        checks   = 0;
        failures = 0;

        // Reset dominates enables.
        clear  = 1'b1;
        load   = 1'b1;
        transf = 1'b1;
        in     = 16'h0005;
        #1;
        chk("rst_out_t0", 32'(out), 32'h0);
        chk("rst_ovf_t0", 32'(ovf), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_held", 32'(out), 32'h0);
        chk("rst_acc_held", 32'(dut.acc_q), 32'h0);
        chk("rst_ovf_held", 32'(ovf), 32'h0);
        @(negedge clk);
        clear  = 1'b0;
        load   = 1'b0;
        transf = 1'b0;

        // Basic accumulate then transfer.
        step(1'b1, 1'b0, 16'h0001);
        chk("acc_after_1", 32'(dut.acc_q), 32'h1);
        chk("out_hold_0", 32'(out), 32'h0);
        step(1'b1, 1'b0, 16'h0002);
        chk("acc_after_2", 32'(dut.acc_q), 32'h3);
        step(1'b0, 1'b1, 16'h00AA);
        chk("out_xfer_3", 32'(out), 32'h3);
        chk("acc_hold_3", 32'(dut.acc_q), 32'h3);

        // Simultaneous load and transfer.
        step(1'b1, 1'b1, 16'h0004);
        chk("sim_out_pre", 32'(out), 32'h3);
        chk("sim_acc_new", 32'(dut.acc_q), 32'h7);
        step(1'b0, 1'b1, 16'h0000);
        chk("sim_out_next", 32'(out), 32'h7);
        step(1'b0, 1'b0, 16'h1111);
        chk("out_hold_7", 32'(out), 32'h7);

        // Wrap-around and sticky ovf.
        pulse_clear();
        chk("clr_acc", 32'(dut.acc_q), 32'h0);
        step(1'b1, 1'b0, 16'hFFFF);
        chk("wrap_acc_ffff", 32'(dut.acc_q), 32'hFFFF);
        chk("wrap_ovf_0", 32'(ovf), 32'h0);
        step(1'b1, 1'b0, 16'h0002);
        chk("wrap_acc_1", 32'(dut.acc_q), 32'h1);
        chk("wrap_ovf_1", 32'(ovf), 32'h1);
        step(1'b1, 1'b0, 16'h0001);
        chk("sticky_acc_2", 32'(dut.acc_q), 32'h2);
        chk("sticky_ovf_a", 32'(ovf), 32'h1);
        step(1'b1, 1'b0, 16'h0001);
        chk("sticky_ovf_b", 32'(ovf), 32'h1);
        step(1'b1, 1'b0, 16'h0000);
        chk("zero_add_acc", 32'(dut.acc_q), 32'h3);

        // Async clear mid-stream, ovf still set from the wrap.
        step(1'b1, 1'b0, 16'h1231);
        chk("mid_acc_1234", 32'(dut.acc_q), 32'h1234);
        step(1'b0, 1'b1, 16'h0000);
        chk("mid_out_1234", 32'(out), 32'h1234);
        chk("mid_ovf_set", 32'(ovf), 32'h1);
        @(negedge clk);
        load   = 1'b1;
        transf = 1'b1;
        in     = 16'h0005;
        #2;
        clear  = 1'b1;
        #1;
        chk("async_out_0", 32'(out), 32'h0);
        chk("async_ovf_0", 32'(ovf), 32'h0);
        chk("async_acc_0", 32'(dut.acc_q), 32'h0);
        @(posedge clk);
        #1;
        chk("clr_dom_acc", 32'(dut.acc_q), 32'h0);
        chk("clr_dom_out", 32'(out), 32'h0);
        @(negedge clk);
        clear  = 1'b0;
        load   = 1'b0;
        transf = 1'b0;
        step(1'b1, 1'b0, 16'h0008);
        chk("post_clr_acc", 32'(dut.acc_q), 32'h8);

        // Doubling sequence with transfer each edge.
        pulse_clear();
        model = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            pow = 16'h0001 << i;
            step(1'b1, 1'b1, pow);
            chk($sformatf("dbl_out_%0d", i), 32'(out), 32'(model));
            model = model + pow;
            chk($sformatf("dbl_acc_%0d", i), 32'(dut.acc_q), 32'(model));
        end
        chk("dbl_final_acc", 32'(dut.acc_q), 32'hFFFF);
        chk("dbl_final_ovf", 32'(ovf), 32'h0);
        step(1'b0, 1'b1, 16'h0000);
        chk("dbl_final_out", 32'(out), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accumulator.md
Name: accumulator

Overview:
- 16-bit running-sum accumulator for the Somador datapath.
- Adds the input word into an internal accumulator register when `load` is asserted.
- Copies the accumulator into a separate output register when `transf` is asserted.
- The output register holds the last transferred sum, so downstream logic sees a stable value while accumulation continues.

Parameters:
- WIDTH, 16, data width of `in`, the accumulator register and `out`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-high reset. Forces all state to zero immediately and holds it while high.
- load  input  1  accumulate enable, sampled at the rising edge of clk.
- transf  input  1  transfer enable, sampled at the rising edge of clk.
- in  input  WIDTH  addend.
- out  output  WIDTH  registered output, holding the last transferred accumulator value.
- ovf  output  1  sticky carry-out flag. Extra port; it may be left unconnected.

Behaviour:
- State: acc[WIDTH-1:0], out[WIDTH-1:0], ovf.
- Reset:
  - While clear=1, asynchronously acc=0, out=0, ovf=0.
  - clear dominates load and transf.
  - Deassertion takes effect at the next rising edge with clear=0.
- Accumulate: at a rising edge with load=1:
  - acc <= (acc + in) mod 2^WIDTH.
  - ovf <= ovf | carry-out of that addition.
- Transfer: at a rising edge with transf=1, out <= acc, using the value of acc before this edge's accumulate.
- Simultaneous load=1 and transf=1:
  - out receives the pre-add acc.
  - acc receives the new sum.
  - The new sum appears on out only at a later edge with transf=1.
- Hold:
  - load=0 leaves acc and ovf unchanged.
  - transf=0 leaves out unchanged.
- Latency:
  - in to acc: 1 cycle.
  - acc to out: 1 cycle.
  - in to out: minimum 2 edges (load, then transf).
- Wrap-around:
  - Addition is unsigned and modulo 2^WIDTH.
  - Example: 0xFFFF + 0x0001 gives acc=0x0000 and sets ovf=1.
  - ovf stays set until clear.
- in=0 with load=1: acc is unchanged, except that the register is rewritten.
- Reset mid-operation: an asynchronous clear during any cycle zeroes everything within the same timestep; no pending update survives.
- X-safety: load and transf are treated as plain enables; no handshake and no back-pressure.

Decomposition:
- Shared package/header: WIDTH default (16) and zero constant.
- Sub-module `somador`: WIDTH-bit combinational adder.
  - Inputs a, b.
  - Outputs sum[WIDTH-1:0] and cout.
  - Instantiated once for acc + in.
- Top level holds the acc, out and ovf registers and the enable muxing.

Test Plan:
1. clear=1 at time 0, toggle clk, drive load=1, transf=1, in=0x0005. Required: out=0, acc=0, ovf=0 throughout. Then deassert clear.
2. From acc=0: load=1, in=0x0001 for one edge, then in=0x0002 for one edge, then load=0, transf=1. Required: after the transfer edge out=0x0003.
3. Simultaneous: acc=0x0003, load=1, transf=1, in=0x0004 for one edge. Required: out=0x0003 and acc=0x0007. Next edge with transf=1, load=0: out=0x0007.
4. Wrap: accumulate 0xFFFF then 0x0002. Required: acc=0x0001 and ovf=1. ovf stays 1 after further loads of 0x0001 until clear.
5. Async clear mid-stream: acc=0x1234, out=0x1234; pulse clear=1 between clock edges. Required: out=0 and ovf=0 immediately, without waiting for clk. The first load after release, with in=0x0008, gives acc=0x0008.
6. Doubling sequence: in=1,2,4,…,0x8000 with load each edge and transf every edge. Required: out lags acc by one edge. Final acc=0xFFFF and ovf=0.
